// File: rtl/recip_pkg.sv
// rtl/recip_pkg.sv - shared types, defaults and seed-table math for the reciprocal unit
package recip_pkg;

  typedef enum logic [2:0] {IDLE, SEED, MUL1, MUL2, DONE} state_t;

  localparam int DEFAULT_GUARD = 4;

  // round(2^frac / (1 + (i+0.5)/2^lut_bits)) done in integers: N=2^(frac+L+1), D=2^(L+1)+2i+1
  function automatic logic [31:0] seed_entry(input int i, input int lut_bits, input int frac);
    logic [63:0] num2;
    logic [63:0] den;
    num2 = 64'd1 << (frac + lut_bits + 2);
    den  = (64'd1 << (lut_bits + 1)) + 64'(2 * i + 1);
    seed_entry = 32'((num2 + den) / (64'd2 * den));
  endfunction

endpackage

// File: rtl/recip_seed_lut.sv
// rtl/recip_seed_lut.sv - combinational seed table, entry i = 1/(1+(i+0.5)/2^LUT_BITS) in Q2.F
module recip_seed_lut
  import recip_pkg::*;
#(
  parameter int LUT_BITS = 4,
  parameter int F        = 19
) (
  input  logic [LUT_BITS-1:0] idx_i,
  output logic [F+1:0]        y0_o
);

  logic [F+1:0] table_w [2**LUT_BITS];

  for (genvar g = 0; g < 2**LUT_BITS; g++) begin : g_tbl
    assign table_w[g] = (F+2)'(seed_entry(g, LUT_BITS, F));
  end

  assign y0_o = table_w[idx_i];

endmodule

// File: rtl/reciprocal_nr_unit.sv
// rtl/reciprocal_nr_unit.sv - iterative Newton-Raphson reciprocal, U1.(WIDTH-1) in and out
// RECIP_NORM_CHK_EN: adds err port and flags unnormalized operands instead of forcing the MSB.
module reciprocal_nr_unit
  import recip_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LUT_BITS = 4,
  parameter int ITER     = 2,
  parameter int GUARD    = DEFAULT_GUARD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             busy
`ifdef RECIP_NORM_CHK_EN
  ,
  output logic             err
`endif
);

  localparam int F  = WIDTH - 1 + GUARD;
  localparam int QW = F + 2;
  localparam logic [QW-1:0]    TWO_Q  = QW'(2) << F;
  localparam logic [QW-1:0]    ONE_Q  = QW'(1) << F;
  localparam logic [QW-1:0]    HALF_Q = QW'(1) << (GUARD - 1);
  localparam logic [2:0]       ITER_L = 3'(ITER);
  localparam logic [WIDTH-1:0] SAT_Y  = WIDTH'(1) << (WIDTH - 1);

  state_t           state_q;
  logic [QW-1:0]    x_q, y_q, t_q;
  logic [2:0]       iter_q, iter_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic [WIDTH-1:0] out_y_q;
  logic [WIDTH-1:0] x_norm;
  logic             bad_op;

`ifdef RECIP_NORM_CHK_EN
  logic bad_q, err_q;
  assign x_norm = in_x;
  assign bad_op = bad_q;
  assign err    = err_q;
`else
  assign x_norm = in_x | SAT_Y;
  assign bad_op = 1'b0;
`endif

  logic [QW-1:0] seed_y0;

  recip_seed_lut #(
    .LUT_BITS(LUT_BITS),
    .F       (F)
  ) u_seed (
    .idx_i(x_q[F-1 -: LUT_BITS]),
    .y0_o (seed_y0)
  );

  // Single shared multiplier: x*y in MUL1, y*(2-t) in MUL2
  logic [QW-1:0]   mul_a, mul_b, prod_q2f;
  logic [2*QW-1:0] full_prod;

  always_comb begin
    mul_a = x_q;
    mul_b = y_q;
    if (state_q == MUL2) begin
      mul_a = y_q;
      mul_b = TWO_Q - t_q;
    end
  end

  assign full_prod = mul_a * mul_b;
  assign prod_q2f  = QW'(full_prod >> F);
  assign iter_d    = iter_q + 3'd1;

  // Round to nearest so exact reciprocals (1/1.0) survive the downward truncation bias
  logic [QW-1:0]    y_rnd;
  logic [WIDTH-1:0] y_final;

  assign y_rnd   = y_q + HALF_Q;
  assign y_final = (y_rnd >= ONE_Q) ? SAT_Y : WIDTH'(y_rnd >> GUARD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      t_q         <= '0;
      iter_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      busy_q      <= 1'b0;
`ifdef RECIP_NORM_CHK_EN
      bad_q       <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            x_q        <= QW'({x_norm, {GUARD{1'b0}}});
            state_q    <= SEED;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef RECIP_NORM_CHK_EN
            bad_q      <= ~in_x[WIDTH-1];
`endif
          end
        end
        SEED: begin
          y_q     <= seed_y0;
          iter_q  <= '0;
          state_q <= bad_op ? DONE : MUL1;
        end
        MUL1: begin
          t_q     <= prod_q2f;
          state_q <= MUL2;
        end
        MUL2: begin
          y_q     <= prod_q2f;
          iter_q  <= iter_d;
          state_q <= (iter_d < ITER_L) ? MUL1 : DONE;
        end
        DONE: begin
          // First DONE cycle registers the result; the handshake is taken from the next cycle on
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_y_q     <= bad_op ? '1 : y_final;
`ifdef RECIP_NORM_CHK_EN
            err_q       <= bad_q;
`endif
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef RECIP_NORM_CHK_EN
            err_q       <= 1'b0;
`endif
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_reciprocal_nr_unit.sv
// tb/tb_reciprocal_nr_unit.sv - directed-vector bench for reciprocal_nr_unit
module tb_reciprocal_nr_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;
  logic        busy;
  logic        err_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reciprocal_nr_unit dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .busy     (busy)
`ifdef RECIP_NORM_CHK_EN
    ,
    .err      (err_w)
`endif
  );

`ifndef RECIP_NORM_CHK_EN
  assign err_w = 1'b0;
`endif

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    int          tol;
    int          lat;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int req, input int tol);
    checks++;
    if ((act > req + tol) || (act < req - tol)) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h tol=%0d", name, act, req, tol);
    end
  endtask

  task automatic start(input logic [15:0] x);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL start_timeout actual=%0b required=1", in_ready);
    end
    in_valid = 1'b1;
    in_x     = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [15:0] y, output int lat, output logic e);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL result_timeout actual=%0b required=1", out_valid);
    end
    y = out_y;
    e = err_w;
  endtask

  task automatic ack();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] y, y_held, x;
    int          lat;
    logic        e;
    real         model, diff;

    vecs[0] = '{16'h8000, 16'h8000, 0, 6, 1'b0};
    vecs[1] = '{16'hC000, 16'h5555, 1, 6, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h4000, 1, 6, 1'b0};
    vecs[3] = '{16'hA000, 16'h6666, 1, 6, 1'b0};
    vecs[4] = '{16'h9000, 16'h71C7, 1, 6, 1'b0};
    vecs[5] = '{16'hE000, 16'h4925, 1, 6, 1'b0};
`ifdef RECIP_NORM_CHK_EN
    vecs[6] = '{16'h4000, 16'hFFFF, 0, 2, 1'b1};
    vecs[7] = '{16'h0000, 16'hFFFF, 0, 2, 1'b1};
`else
    vecs[6] = '{16'h4000, 16'h5555, 1, 6, 1'b0};
    vecs[7] = '{16'h0000, 16'h8000, 0, 6, 1'b0};
`endif

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_y", {16'd0, out_y}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
`ifdef RECIP_NORM_CHK_EN
    chk("reset_err", {31'd0, err_w}, 32'd0);
`endif

    for (int i = 0; i < 8; i++) begin
      start(vecs[i].x);
      wait_result(y, lat, e);
      chk_tol($sformatf("vec%0d_y", i), int'(y), int'(vecs[i].y), vecs[i].tol);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
`ifdef RECIP_NORM_CHK_EN
      chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].err});
`endif
      ack();
`ifdef RECIP_NORM_CHK_EN
      chk($sformatf("vec%0d_err_clear", i), {31'd0, err_w}, 32'd0);
`endif
    end

    // Back-pressure: result held, new request ignored until the handshake
    start(16'hA000);
    wait_result(y_held, lat, e);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_x     = 16'h8000;
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_out_y", c), {16'd0, out_y}, {16'd0, y_held});
      chk($sformatf("hold%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
      chk($sformatf("hold%0d_out_valid", c), {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("next_accept_busy", {31'd0, busy}, 32'd1);
    wait_result(y, lat, e);
    chk("next_accept_y", {16'd0, y}, 32'h8000);
    chk("next_accept_latency", 32'(lat), 32'd6);
    ack();

    // Reset while in MUL1 aborts the operation
    start(16'hE000);
    @(posedge clk);
    #1;
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    start(16'hC000);
    wait_result(y, lat, e);
    chk_tol("after_abort_y", int'(y), 32'h5555, 1);
    chk("after_abort_latency", 32'(lat), 32'd6);
    ack();

    // Sampled sweep of normalized operands against a real-valued model
    for (int k = 0; k < 4096; k++) begin
      x = 16'(32'h8000 + k * 8 + (k % 8));
      start(x);
      wait_result(y, lat, e);
      model = 1073741824.0 / real'(x);
      diff  = real'(y) - model;
      if (diff < 0.0) diff = -diff;
      checks++;
      if (diff > 1.0) begin
        failures++;
        $display("FAIL sweep_x%0h actual=%0h required=%f", x, y, model);
      end
      ack();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
